// File: rtl/sphere_packet_assembler.sv
// Packs SPI bytes MSB-first into 64-bit sphere words, buffers them in a FIFO and
// delivers one word per rising edge of the controller's ready level.
module sphere_packet_assembler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [63:0] RESET_WORD = 64'h0
) (
  input  logic                        CLK100MHZ,
  input  logic                        rst,
  input  logic                        cs_n,
  input  logic                        rx_dv,
  input  logic [7:0]                  rx_byte,
  input  logic                        recv_interrupt,
  output logic                        recv_dv,
  output logic [63:0]                 recv_64bit,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_error
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StPush} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [63:0]   word_q, word_d;
  logic          frame_err_set;
  logic          take;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          irq_q;
  logic          push, pop, full, wr_en;

  assign take  = rx_dv & ~cs_n;
  assign push  = (state_q == StPush);
  assign full  = (fifo_count == CW'(FIFO_DEPTH));
  assign pop   = recv_interrupt & ~irq_q & (fifo_count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign wr_en = push & (~full | pop);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    frame_err_set = 1'b0;
    unique case (state_q)
      StIdle, StPush: begin
        if (take) begin
          word_d  = {56'h0, rx_byte};
          cnt_d   = 4'd1;
          state_d = StCollect;
        end else begin
          cnt_d   = 4'd0;
          state_d = StIdle;
        end
      end
      StCollect: begin
        if (cs_n) begin
          frame_err_set = 1'b1;
          cnt_d         = 4'd0;
          state_d       = StIdle;
        end else if (take) begin
          word_d = {word_q[55:0], rx_byte};
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = StPush;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      word_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      irq_q       <= 1'b0;
      recv_dv     <= 1'b0;
      recv_64bit  <= RESET_WORD;
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      irq_q      <= recv_interrupt;
      recv_dv    <= pop;
      fifo_count <= fifo_count + CW'(wr_en) - CW'(pop);
      if (pop) begin
        recv_64bit <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + AW'(1);
      end
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (push && !wr_en) overflow <= 1'b1;
      if (frame_err_set) frame_error <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and fifo_count.
  always_ff @(posedge CLK100MHZ) begin
    if (!rst && wr_en) mem[wr_ptr] <= word_q;
  end

endmodule

// File: tb/tb_sphere_packet_assembler.sv
// Self-checking bench: per-cycle queue-based reference model plus a vector table and
// directed corner-case sequences.
module tb_sphere_packet_assembler;

  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RW    = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        irq = 1'b0;
  logic        recv_dv;
  logic [63:0] recv_64bit;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        frame_error;

  always #5 clk = ~clk;

  sphere_packet_assembler #(
    .FIFO_DEPTH(DEPTH),
    .RESET_WORD(RW)
  ) dut (
    .CLK100MHZ     (clk),
    .rst           (rst),
    .cs_n          (cs_n),
    .rx_dv         (rx_dv),
    .rx_byte       (rx_byte),
    .recv_interrupt(irq),
    .recv_dv       (recv_dv),
    .recv_64bit    (recv_64bit),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .frame_error   (frame_error)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [63:0] m_fifo[$];
  logic [7:0]  m_bytes[$];
  bit          m_pend = 0;
  logic [63:0] m_pword = '0;
  bit          m_irq_prev = 0;
  bit          m_dv = 0;
  logic [63:0] m_word = RW;
  bit          m_ovf = 0;
  bit          m_ferr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic model_step();
    if (rst) begin
      m_fifo.delete();
      m_bytes.delete();
      m_pend     = 0;
      m_irq_prev = 0;
      m_dv       = 0;
      m_word     = RW;
      m_ovf      = 0;
      m_ferr     = 0;
      return;
    end
    m_dv = 0;
    if (irq && !m_irq_prev && m_fifo.size() > 0) begin
      m_word = m_fifo.pop_front();
      m_dv   = 1;
    end
    if (m_pend) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pword);
      else m_ovf = 1;
      m_pend = 0;
    end
    if (!cs_n && rx_dv) begin
      m_bytes.push_back(rx_byte);
      if (m_bytes.size() == 8) begin
        for (int i = 0; i < 8; i++) m_pword[63-8*i -: 8] = m_bytes[i];
        m_pend = 1;
        m_bytes.delete();
      end
    end else if (cs_n && m_bytes.size() > 0) begin
      m_ferr = 1;
      m_bytes.delete();
    end
    m_irq_prev = irq;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("m_recv_dv", recv_dv, m_dv);
    check("m_recv_64bit", recv_64bit, m_word);
    check("m_fifo_count", fifo_count, 64'(m_fifo.size()));
    check("m_overflow", overflow, m_ovf);
    check("m_frame_error", frame_error, m_ferr);
  endtask

  task automatic do_reset();
    rst = 1; cs_n = 1; rx_dv = 0; irq = 0;
    step();
    rst = 0;
  endtask

  task automatic send_word(input logic [63:0] w);
    cs_n = 0;
    for (int i = 0; i < 8; i++) begin
      rx_dv   = 1;
      rx_byte = w[63-8*i -: 8];
      step();
    end
    rx_dv = 0;
  endtask

  task automatic expect_pop(input string nm, input bit exp_dv, input logic [63:0] exp_w);
    irq = 1;
    step();
    check({nm, "_dv"}, recv_dv, exp_dv);
    if (exp_dv) check({nm, "_word"}, recv_64bit, exp_w);
    irq = 0;
    step();
    check({nm, "_dv_low"}, recv_dv, 1'b0);
  endtask

  typedef struct {
    logic        cs;
    logic        dv;
    logic [7:0]  b;
    logic        irq;
    logic        exp_dv;
    logic [2:0]  exp_cnt;
    logic [63:0] exp_word;
  } vec_t;

  vec_t tbl[13];
  int   dv_seen;
  logic [63:0] wds[5];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, RW};
    for (int i = 1; i <= 8; i++) tbl[i] = '{1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 3'd0, RW};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, RW};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 64'h0102030405060708};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 64'h0102030405060708};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 64'h0102030405060708};

    // Reset state
    do_reset();
    check("rst_dv", recv_dv, 1'b0);
    check("rst_word", recv_64bit, RW);
    check("rst_count", fifo_count, 3'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ferr", frame_error, 1'b0);

    // Basic delivery vectors
    for (int i = 0; i < 13; i++) begin
      cs_n = tbl[i].cs; rx_dv = tbl[i].dv; rx_byte = tbl[i].b; irq = tbl[i].irq;
      step();
      check($sformatf("tbl%0d_dv", i), recv_dv, tbl[i].exp_dv);
      check($sformatf("tbl%0d_cnt", i), fifo_count, tbl[i].exp_cnt);
      check($sformatf("tbl%0d_word", i), recv_64bit, tbl[i].exp_word);
    end
    check("tbl_ferr", frame_error, 1'b0);

    // Partial frame
    do_reset();
    cs_n = 0;
    for (int i = 0; i < 3; i++) begin
      rx_dv = 1; rx_byte = 8'h50 + 8'(i); step();
    end
    rx_dv = 0; cs_n = 1; step();
    check("part_ferr", frame_error, 1'b1);
    check("part_count", fifo_count, 3'd0);
    send_word(64'h1122334455667788);
    cs_n = 1; step(); step();
    expect_pop("part_next", 1'b1, 64'h1122334455667788);

    // Overflow with back-to-back words (byte in PUSH cycle starts next word)
    wds[0] = {8{8'hAA}}; wds[1] = {8{8'hBB}}; wds[2] = {8{8'hCC}};
    wds[3] = {8{8'hDD}}; wds[4] = {8{8'hEE}};
    for (int i = 0; i < 5; i++) send_word(wds[i]);
    cs_n = 1; step(); step();
    check("ovf_count", fifo_count, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    for (int i = 0; i < 4; i++) expect_pop($sformatf("ovf_pop%0d", i), 1'b1, wds[i]);
    expect_pop("ovf_pop_empty", 1'b0, '0);

    // Reset mid-frame with a buffered word and sticky flags set
    send_word(64'h0F0E0D0C0B0A0908);
    cs_n = 0;
    for (int i = 0; i < 5; i++) begin
      rx_dv = 1; rx_byte = 8'h30 + 8'(i); step();
    end
    rx_dv = 0; rst = 1; step(); rst = 0;
    check("mrst_dv", recv_dv, 1'b0);
    check("mrst_word", recv_64bit, RW);
    check("mrst_count", fifo_count, 3'd0);
    check("mrst_ovf", overflow, 1'b0);
    check("mrst_ferr", frame_error, 1'b0);
    send_word(64'hA1B2C3D4E5F60718);
    cs_n = 1; step(); step();
    check("mrst_ferr_after", frame_error, 1'b0);
    expect_pop("mrst_pop", 1'b1, 64'hA1B2C3D4E5F60718);

    // Interrupt held high, then empty edge, then late push
    do_reset();
    send_word(64'h1111111111111111);
    send_word(64'h2222222222222222);
    cs_n = 1; step(); step();
    irq = 1; dv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (recv_dv) dv_seen++;
    end
    check("lvl_pulses", 64'(dv_seen), 64'd1);
    irq = 0; step();
    expect_pop("lvl_second", 1'b1, 64'h2222222222222222);
    irq = 1; step();
    check("empty_edge_dv", recv_dv, 1'b0);
    send_word(64'h3333333333333333);
    cs_n = 1; step(); step();
    check("late_push_dv", recv_dv, 1'b0);
    check("late_push_count", fifo_count, 3'd1);
    irq = 0; step();
    expect_pop("late_push_pop", 1'b1, 64'h3333333333333333);

    // Full FIFO: PUSH cycle coincides with a pop
    do_reset();
    for (int i = 0; i < 4; i++) wds[i] = {8{8'h40 + 8'(i)}};
    wds[4] = 64'hFEDCBA9876543210;
    for (int i = 0; i < 5; i++) send_word(wds[i]);
    irq = 1; step();
    check("full_pp_dv", recv_dv, 1'b1);
    check("full_pp_word", recv_64bit, wds[0]);
    check("full_pp_count", fifo_count, 3'd4);
    check("full_pp_ovf", overflow, 1'b0);
    irq = 0; cs_n = 1; step();
    for (int i = 1; i < 5; i++) expect_pop($sformatf("full_pop%0d", i), 1'b1, wds[i]);
    check("full_ovf_end", overflow, 1'b0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      cs_n    = ($urandom_range(0, 19) == 0);
      rx_dv   = ($urandom_range(0, 1) == 1);
      rx_byte = 8'($urandom);
      if ($urandom_range(0, 3) == 0) irq = ~irq;
      step();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sphere_packet_assembler.md
SPHERE_PACKET_ASSEMBLER -- requirements
Module: sphere_packet_assembler

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of buffered 64-bit sphere words; power of two, >= 2.
REQ-002 Parameter: RESET_WORD, default 64'h0, value of recv_64bit after reset.
REQ-003 Port: CLK100MHZ  in  1  sole clock; all logic on its rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: cs_n  in  1  SPI frame select, active-low; high = no frame in progress.
REQ-006 Port: rx_dv  in  1  one-cycle pulse; rx_byte valid this cycle.
REQ-007 Port: rx_byte  in  8  received SPI byte.
REQ-008 Port: recv_interrupt  in  1  controller ready level; a rising edge requests one sphere word.
REQ-009 Port: recv_dv  out  1  one-cycle pulse; recv_64bit carries a new word.
REQ-010 Port: recv_64bit  out  64  last delivered sphere word; held between deliveries.
REQ-011 Port: fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
REQ-012 Port: overflow  out  1  sticky; a completed word was dropped because the FIFO was full.
REQ-013 Port: frame_error  out  1  sticky; a frame ended with a partial word.

Function
REQ-014 The assembler SHALL use three states: IDLE (byte count 0), COLLECT (1-7 bytes held) and PUSH (8 bytes held, one cycle).
REQ-015 The assembler SHALL ignore rx_dv while cs_n is high.
REQ-016 The assembler SHALL pack bytes MSB-first: byte 1 goes to bits [63:56] and byte 8 goes to bits [7:0].
REQ-017 When the 8th byte is sampled at edge N, the assembler SHALL enter PUSH. At edge N+1 it SHALL write the word into the FIFO and return to IDLE; fifo_count reflects the write after edge N+1.
REQ-018 An rx_dv sampled in PUSH SHALL be taken as byte 1 of the next word; no byte is lost.
REQ-019 If cs_n is sampled high while in COLLECT, the assembler SHALL discard the partial word, set frame_error and go to IDLE.
REQ-020 cs_n rising while in IDLE or PUSH SHALL NOT set frame_error; a pending PUSH still completes.
REQ-021 On a push with the FIFO full and no pop in the same cycle, the assembler SHALL drop the word, set overflow, and leave the FIFO contents unchanged.
REQ-022 The delivery logic SHALL keep a registered copy of recv_interrupt. A rising edge is recv_interrupt high while that copy is low.
REQ-023 On a rising edge sampled at edge M with fifo_count > 0, the block SHALL pop the oldest word. recv_64bit SHALL take that word and recv_dv SHALL be 1 in the cycle after edge M only.
REQ-024 On a rising edge with the FIFO empty, the block SHALL NOT deliver. A later push SHALL NOT deliver until the next rising edge.
REQ-025 The block SHALL deliver at most one word per rising edge of recv_interrupt, however long the level stays high.
REQ-026 On a simultaneous push and pop, both SHALL succeed and fifo_count SHALL stay unchanged, including when the FIFO is full.
REQ-027 Delivery order SHALL be strictly FIFO. FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL force all outputs and state as follows:
- state IDLE, byte count 0
- FIFO empty, fifo_count 0
- recv_dv 0, recv_64bit RESET_WORD
- overflow 0, frame_error 0
- interrupt copy 0
REQ-029 Reset asserted mid-frame or in PUSH SHALL discard the partial or pending word without setting frame_error or overflow.
REQ-030 After reset deasserts, the first rx_dv with cs_n low SHALL be taken as byte 1.

Verification
REQ-031 Basic delivery:
- stimulus: cs_n low; bytes 01,02,...,08; cs_n high; then one recv_interrupt rising edge.
- response: fifo_count 1; one recv_dv pulse with recv_64bit = 64'h0102030405060708; fifo_count 0.
REQ-032 Overflow:
- stimulus: 5 words, bytes AA..., BB..., CC..., DD..., EE..., with no interrupt edges.
- response: fifo_count 4, overflow 1; then 4 edges deliver AA.., BB.., CC.., DD.. in order; a 5th edge gives no recv_dv.
REQ-033 Partial frame:
- stimulus: 3 bytes, then cs_n high.
- response: frame_error 1, fifo_count 0; the next full 8-byte frame assembles correctly.
REQ-034 Interrupt level and empty FIFO:
- stimulus: recv_interrupt held high 20 cycles with 2 words buffered; then an edge while the FIFO is empty, then a push.
- response: exactly one recv_dv while held high; no recv_dv from the empty edge or the push until the next edge.
REQ-035 Full-FIFO push and pop:
- stimulus: FIFO full; PUSH cycle coincides with a pop.
- response: fifo_count stays 4, overflow stays 0, and the new word is delivered 4 pops later.
REQ-036 Reset mid-frame:
- stimulus: rst pulsed after 5 bytes.
- response: all outputs at their reset values (recv_64bit = RESET_WORD); 8 new bytes then assemble correctly.
